// File: rtl/ysyx_23060059_ifu.sv
// Instruction fetch unit: issues one icache read at a time, holds the fetched word for the IDU,
// and handles EXU redirects (with optional fence.i icache flush) including in-flight drops.
module ysyx_23060059_ifu #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_fencei_valid,
  output logic        o_ic_arvalid,
  output logic [31:0] o_ic_addr,
  input  logic        i_ic_arready,
  input  logic        i_ic_rvalid,
  input  logic [31:0] i_ic_rdata,
  output logic        o_ic_rready,
  output logic        o_ic_flush_valid,
  input  logic        i_ic_bvalid,
  output logic        o_ic_bready,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready
);

  typedef enum logic [2:0] {StRst, StFetch, StWait, StHold, StFlush} state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_drop;
  logic [31:0] r_tgt;
  logic        r_fencei;

  logic [31:0] w_tgt;
  logic        w_drop;
  logic [31:0] w_drop_tgt;
  logic        w_drop_fencei;
  logic        w_unused_pc_lsb;

  assign w_tgt           = {i_redirect_pc[31:2], 2'b00};
  assign w_unused_pc_lsb = ^i_redirect_pc[1:0];

  // Pending-drop bookkeeping as it would stand after this cycle's redirect, if any.
  assign w_drop        = r_drop | i_redirect_valid;
  assign w_drop_tgt    = i_redirect_valid ? w_tgt : r_tgt;
  assign w_drop_fencei = r_fencei | (i_redirect_valid & i_fencei_valid);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= StRst;
      r_pc      <= RESET_PC;
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_drop    <= 1'b0;
      r_tgt     <= '0;
      r_fencei  <= 1'b0;
    end else begin
      unique case (r_state)
        StRst: r_state <= StFetch;
        StFetch: begin
          if (i_ic_arready) begin
            r_state <= StWait;
            if (i_redirect_valid) begin
              r_drop   <= 1'b1;
              r_tgt    <= w_tgt;
              r_fencei <= i_fencei_valid;
            end
          end else if (i_redirect_valid) begin
            r_pc    <= w_tgt;
            r_state <= i_fencei_valid ? StFlush : StFetch;
          end
        end
        StWait: begin
          if (i_ic_rvalid) begin
            if (w_drop) begin
              r_pc     <= w_drop_tgt;
              r_drop   <= 1'b0;
              r_fencei <= 1'b0;
              r_state  <= w_drop_fencei ? StFlush : StFetch;
            end else begin
              r_inst    <= i_ic_rdata;
              r_inst_pc <= r_pc;
              r_state   <= StHold;
            end
          end else begin
            r_drop   <= w_drop;
            r_tgt    <= w_drop_tgt;
            r_fencei <= w_drop_fencei;
          end
        end
        StHold: begin
          if (i_redirect_valid) begin
            r_pc    <= w_tgt;
            r_state <= i_fencei_valid ? StFlush : StFetch;
          end else if (i_inst_ready) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= StFetch;
          end
        end
        StFlush: begin
          if (i_redirect_valid) r_pc <= w_tgt;
          if (i_ic_bvalid) r_state <= StFetch;
        end
        default: r_state <= StRst;
      endcase
    end
  end

  // Moore decode; everything is forced low while reset is asserted.
  assign o_ic_arvalid     = !i_reset && (r_state == StFetch);
  assign o_ic_rready      = !i_reset && (r_state == StWait);
  assign o_ic_flush_valid = !i_reset && (r_state == StFlush);
  assign o_ic_bready      = !i_reset && (r_state == StFlush);
  assign o_inst_valid     = !i_reset && (r_state == StHold);
  assign o_ic_addr        = i_reset ? '0 : r_pc;
  assign o_inst           = i_reset ? '0 : r_inst;
  assign o_inst_pc        = i_reset ? '0 : r_inst_pc;

endmodule

// File: tb/tb_ysyx_23060059_ifu.sv
// Randomized bench for ysyx_23060059_ifu: a transaction-level model tracks the architectural
// fetch PC, the outstanding read, pending flushes and the held instruction.
module tb_ysyx_23060059_ifu;

  localparam logic [31:0] ResetPc = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fencei_valid;
  logic        ic_arvalid;
  logic [31:0] ic_addr;
  logic        ic_arready;
  logic        ic_rvalid;
  logic [31:0] ic_rdata;
  logic        ic_rready;
  logic        ic_flush_valid;
  logic        ic_bvalid;
  logic        ic_bready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  always #5 clk = ~clk;

  ysyx_23060059_ifu #(.RESET_PC(ResetPc)) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_fencei_valid   (fencei_valid),
    .o_ic_arvalid     (ic_arvalid),
    .o_ic_addr        (ic_addr),
    .i_ic_arready     (ic_arready),
    .i_ic_rvalid      (ic_rvalid),
    .i_ic_rdata       (ic_rdata),
    .o_ic_rready      (ic_rready),
    .o_ic_flush_valid (ic_flush_valid),
    .i_ic_bvalid      (ic_bvalid),
    .o_ic_bready      (ic_bready),
    .o_inst_valid     (inst_valid),
    .o_inst           (inst),
    .o_inst_pc        (inst_pc),
    .i_inst_ready     (inst_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: architectural pc, outstanding read, held instruction, pending flush.
  logic [31:0] m_pc;
  logic        m_out;
  logic        m_taint;
  logic [31:0] m_req;
  int          m_lat;
  logic        m_hold;
  logic [31:0] m_inst;
  logic [31:0] m_ipc;
  logic        m_pend;

  // Stimulus knobs (percentages / max latency).
  int k_ar;
  int k_lat;
  int k_redir;
  int k_rdy;

  logic [31:0] targets [6];

  task automatic do_reset(input int n);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    fencei_valid   = 1'b0;
    ic_arready     = 1'b0;
    ic_rvalid      = 1'b0;
    ic_bvalid      = 1'b0;
    inst_ready     = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_arvalid", {31'd0, ic_arvalid}, 32'd0);
      check("rst_flush", {31'd0, ic_flush_valid | ic_bready | ic_rready}, 32'd0);
      check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_addr", ic_addr, 32'd0);
      check("rst_inst", inst | inst_pc, 32'd0);
    end
    // First cycle after release is the idle state; late responses here must be ignored.
    rst        = 1'b0;
    ic_rvalid  = 1'b1;
    ic_bvalid  = 1'b1;
    ic_rdata   = 32'hDEAD_BEEF;
    ic_arready = 1'b1;
    #1;
    check("idle_arvalid", {31'd0, ic_arvalid}, 32'd0);
    check("idle_inst_valid", {31'd0, inst_valid}, 32'd0);
    m_pc = ResetPc; m_out = 1'b0; m_taint = 1'b0; m_hold = 1'b0; m_pend = 1'b0;
    m_req = '0; m_lat = 0; m_inst = '0; m_ipc = '0;
  endtask

  task automatic step();
    logic exp_ar, hs, resp, redir, was_hold, flushing;
    logic [31:0] tgt;
    @(negedge clk);
    exp_ar = !m_out && !m_hold && !m_pend;
    check("arvalid", {31'd0, ic_arvalid}, {31'd0, exp_ar});
    if (exp_ar) check("ic_addr", ic_addr, m_pc);
    if (m_out) check("ic_addr_stable", ic_addr, m_req);
    check("rready", {31'd0, ic_rready}, {31'd0, m_out});
    check("flush_valid", {31'd0, ic_flush_valid}, {31'd0, m_pend && !m_out});
    check("bready", {31'd0, ic_bready}, {31'd0, m_pend && !m_out});
    check("inst_valid", {31'd0, inst_valid}, {31'd0, m_hold});
    if (m_hold) begin
      check("inst", inst, m_inst);
      check("inst_pc", inst_pc, m_ipc);
    end

    ic_arready = ($urandom_range(0, 99) < k_ar);
    ic_rvalid  = m_out && (m_lat == 0);
    ic_rdata   = $urandom;
    ic_bvalid  = ic_flush_valid && ($urandom_range(0, 2) == 0);
    inst_ready = ($urandom_range(0, 99) < k_rdy);
    redir      = ($urandom_range(0, 99) < k_redir);
    redirect_valid = redir;
    redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom : targets[$urandom_range(0, 5)];
    fencei_valid   = ($urandom_range(0, 2) == 0);
    tgt = redirect_pc & 32'hFFFF_FFFC;

    was_hold = m_hold;
    flushing = m_pend && !m_out;
    hs   = exp_ar && ic_arready;
    resp = m_out && ic_rvalid;
    if (resp) begin
      m_out = 1'b0;
      if (!m_taint && !redir) begin
        m_hold = 1'b1;
        m_inst = ic_rdata;
        m_ipc  = m_req;
      end
    end else if (m_out) begin
      if (redir) m_taint = 1'b1;
      if (m_lat > 0) m_lat--;
    end
    if (hs) begin
      m_out   = 1'b1;
      m_taint = redir;
      m_req   = m_pc;
      m_lat   = $urandom_range(0, k_lat);
    end
    if (redir) begin
      m_pc = tgt;
      if (was_hold) m_hold = 1'b0;
      if (!flushing) m_pend = m_pend | fencei_valid;
    end else if (was_hold && inst_ready) begin
      m_pc   = m_pc + 32'd4;
      m_hold = 1'b0;
    end
    if (flushing && ic_bvalid) m_pend = 1'b0;
  endtask

  initial begin
    targets[0] = 32'h8000_0010;
    targets[1] = 32'h8000_0100;
    targets[2] = 32'h8000_0003;
    targets[3] = 32'hFFFF_FFFC;
    targets[4] = 32'hFFFF_FFF8;
    targets[5] = 32'h0000_0004;
    redirect_pc = '0;
    ic_rdata    = '0;

    do_reset(3);
    // Best case: every request accepted, 1-cycle hits, IDU always ready.
    k_ar = 100; k_lat = 0; k_redir = 0; k_rdy = 100;
    repeat (20) step();
    // Long misses with a stalling IDU and occasional redirects.
    k_ar = 70; k_lat = 10; k_redir = 4; k_rdy = 20;
    repeat (800) step();
    k_ar = 60; k_lat = 4; k_redir = 12; k_rdy = 60;
    repeat (1500) step();
    do_reset(2);
    k_ar = 50; k_lat = 6; k_redir = 25; k_rdy = 50;
    repeat (1500) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
